// File: rtl/tcp_pkg.sv
// Shared types and constants for the TCP slow-path TX burst controller.
// State encoding, state-read channel indices and the default read-once channel set.
package tcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_CALC,
        ST_PKT_OUT,
        ST_WRITEBACK,
        ST_SCHED_UPDATE
    } tx_burst_state_e;

    localparam int RD_TX_STATE = 0;
    localparam int RD_RX_STATE = 1;
    localparam int RD_TAIL_PTR = 2;
    localparam int RD_TUPLE    = 3;

    localparam int NUM_RD_DEFAULT = 4;

    // The tuple never changes within an event, so it is read on the first iteration only.
    localparam logic [NUM_RD_DEFAULT-1:0] RD_ONCE_MASK_DEFAULT = 4'b1000;

endpackage

// File: rtl/tcp_tx_ctrl_burst_if.sv
// Handshake bundle between the TX burst controller and its neighbours.
// Every *_val/*_rdy pair transfers on a clock edge where both are high; a raised val holds until that edge.
interface tcp_tx_ctrl_burst_if #(
    parameter int FLOWID_W = 8,
    parameter int NUM_RD   = 4,
    parameter int BURST_W  = 3
);
    logic                sched_tx_req_val;
    logic                tx_sched_req_rdy;
    logic [FLOWID_W-1:0] sched_tx_req_flowid;
    logic                sched_tx_update_val;
    logic                sched_tx_update_rdy;
    logic [FLOWID_W-1:0] sched_tx_update_flowid;
    logic                sched_tx_update_more;
    logic [NUM_RD-1:0]   rd_req_val;
    logic [NUM_RD-1:0]   rd_req_rdy;
    logic [NUM_RD-1:0]   rd_resp_val;
    logic [NUM_RD-1:0]   rd_resp_rdy;
    logic [NUM_RD-1:0]   ctrl_datap_store_rd;
    logic                ctrl_datap_store_calc;
    logic                next_tx_state_wr_req_val;
    logic                next_tx_state_wr_req_rdy;
    logic                tx_pkt_val;
    logic                tx_pkt_rdy;
    logic                datap_ctrl_produce_pkt;
    logic                datap_ctrl_more_data;
    logic [BURST_W-1:0]  burst_idx;
    logic [31:0]         stat_pkts_sent;
    logic [31:0]         stat_sched_events;

    modport master (
        input  sched_tx_req_val, sched_tx_req_flowid, sched_tx_update_rdy,
        input  rd_req_rdy, rd_resp_val, next_tx_state_wr_req_rdy, tx_pkt_rdy,
        input  datap_ctrl_produce_pkt, datap_ctrl_more_data,
        output tx_sched_req_rdy, sched_tx_update_val, sched_tx_update_flowid,
        output sched_tx_update_more, rd_req_val, rd_resp_rdy, ctrl_datap_store_rd,
        output ctrl_datap_store_calc, next_tx_state_wr_req_val, tx_pkt_val,
        output burst_idx, stat_pkts_sent, stat_sched_events
    );

    modport slave (
        output sched_tx_req_val, sched_tx_req_flowid, sched_tx_update_rdy,
        output rd_req_rdy, rd_resp_val, next_tx_state_wr_req_rdy, tx_pkt_rdy,
        output datap_ctrl_produce_pkt, datap_ctrl_more_data,
        input  tx_sched_req_rdy, sched_tx_update_val, sched_tx_update_flowid,
        input  sched_tx_update_more, rd_req_val, rd_resp_rdy, ctrl_datap_store_rd,
        input  ctrl_datap_store_calc, next_tx_state_wr_req_val, tx_pkt_val,
        input  burst_idx, stat_pkts_sent, stat_sched_events
    );

endinterface

// File: rtl/tcp_tx_rd_tracker.sv
// Per-channel issued/received bookkeeping for the state-read channels.
// Responses may arrive before the FSM finishes issuing, so they are accepted as soon as a channel is issued.
module tcp_tx_rd_tracker #(
    parameter int NUM_RD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [NUM_RD-1:0] active_i,
    input  logic              in_req_i,
    input  logic              in_resp_i,
    input  logic [NUM_RD-1:0] rd_req_rdy_i,
    input  logic [NUM_RD-1:0] rd_resp_val_i,
    output logic [NUM_RD-1:0] rd_req_val_o,
    output logic [NUM_RD-1:0] rd_resp_rdy_o,
    output logic [NUM_RD-1:0] store_rd_o,
    output logic              all_issued_o,
    output logic              all_received_o
);

    logic [NUM_RD-1:0] issued_q, issued_d;
    logic [NUM_RD-1:0] received_q, received_d;
    logic [NUM_RD-1:0] req_hs;
    logic [NUM_RD-1:0] resp_hs;

    always_comb begin
        rd_req_val_o  = '0;
        rd_resp_rdy_o = '0;
        if (in_req_i) begin
            rd_req_val_o  = active_i & ~issued_q;
            rd_resp_rdy_o = issued_q & ~received_q;
        end else if (in_resp_i) begin
            rd_resp_rdy_o = active_i & ~received_q;
        end
    end

    assign req_hs     = rd_req_val_o & rd_req_rdy_i;
    assign resp_hs    = rd_resp_val_i & rd_resp_rdy_o;
    assign store_rd_o = resp_hs;

    // Completion flags look through this cycle's handshakes so the FSM can advance without a bubble.
    assign all_issued_o   = ((issued_q | req_hs) & active_i) == active_i;
    assign all_received_o = ((received_q | resp_hs) & active_i) == active_i;

    always_comb begin
        issued_d   = issued_q | req_hs;
        received_d = received_q | resp_hs;
        if (clear_i) begin
            issued_d   = '0;
            received_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q   <= '0;
            received_q <= '0;
        end else begin
            issued_q   <= issued_d;
            received_q <= received_d;
        end
    end

endmodule

// File: rtl/tcp_tx_ctrl_burst.sv
// TCP slow-path TX burst controller: read flow state, emit up to MAX_BURST packets, report back.
// Build option TCP_TX_CTRL_STATS_EN adds packet and scheduling-event counters.
module tcp_tx_ctrl_burst
    import tcp_pkg::*;
#(
    parameter int                FLOWID_W     = 8,
    parameter int                NUM_RD       = NUM_RD_DEFAULT,
    parameter logic [NUM_RD-1:0] RD_ONCE_MASK = RD_ONCE_MASK_DEFAULT,
    parameter int                MAX_BURST    = 4,
    parameter int                BURST_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    tcp_tx_ctrl_burst_if.master    bus,
    output tx_burst_state_e        state_dbg_o
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    tx_burst_state_e     state_q, state_d;
    logic [FLOWID_W-1:0] flowid_q, flowid_d;
    logic [BURST_W-1:0]  burst_idx_q, burst_idx_d;
    logic                sent_q, sent_d;
    logic                more_q, more_d;
    logic                upd_more_q, upd_more_d;
    logic                trk_clear, in_req, in_resp;
    logic                all_issued, all_received;
    logic [NUM_RD-1:0]   active;

    // Re-read iterations skip the channels whose contents cannot change within an event.
    assign active = (burst_idx_q == '0) ? '1 : ~RD_ONCE_MASK;

    tcp_tx_rd_tracker #(.NUM_RD(NUM_RD)) u_rd_tracker (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (trk_clear),
        .active_i       (active),
        .in_req_i       (in_req),
        .in_resp_i      (in_resp),
        .rd_req_rdy_i   (bus.rd_req_rdy),
        .rd_resp_val_i  (bus.rd_resp_val),
        .rd_req_val_o   (bus.rd_req_val),
        .rd_resp_rdy_o  (bus.rd_resp_rdy),
        .store_rd_o     (bus.ctrl_datap_store_rd),
        .all_issued_o   (all_issued),
        .all_received_o (all_received)
    );

    always_comb begin
        state_d     = state_q;
        flowid_d    = flowid_q;
        burst_idx_d = burst_idx_q;
        sent_d      = sent_q;
        more_d      = more_q;
        upd_more_d  = upd_more_q;
        trk_clear   = 1'b0;
        in_req      = 1'b0;
        in_resp     = 1'b0;
        bus.tx_sched_req_rdy         = 1'b0;
        bus.sched_tx_update_val      = 1'b0;
        bus.ctrl_datap_store_calc    = 1'b0;
        bus.next_tx_state_wr_req_val = 1'b0;
        bus.tx_pkt_val               = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.tx_sched_req_rdy = 1'b1;
                if (bus.sched_tx_req_val) begin
                    flowid_d    = bus.sched_tx_req_flowid;
                    burst_idx_d = '0;
                    sent_d      = 1'b0;
                    more_d      = 1'b0;
                    upd_more_d  = 1'b0;
                    trk_clear   = 1'b1;
                    state_d     = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                in_req = 1'b1;
                if (all_issued) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                in_resp = 1'b1;
                if (all_received) state_d = ST_CALC;
            end
            ST_CALC: begin
                bus.ctrl_datap_store_calc = 1'b1;
                sent_d  = 1'b0;
                state_d = ST_PKT_OUT;
            end
            ST_PKT_OUT: begin
                bus.tx_pkt_val = bus.datap_ctrl_produce_pkt;
                if (!bus.datap_ctrl_produce_pkt) begin
                    more_d  = bus.datap_ctrl_more_data;
                    state_d = ST_WRITEBACK;
                end else if (bus.tx_pkt_rdy) begin
                    burst_idx_d = burst_idx_q + BURST_W'(1);
                    sent_d      = 1'b1;
                    more_d      = bus.datap_ctrl_more_data;
                    state_d     = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                bus.next_tx_state_wr_req_val = 1'b1;
                if (bus.next_tx_state_wr_req_rdy) begin
                    if (sent_q && more_q && (burst_idx_q != MAX_B)) begin
                        trk_clear = 1'b1;
                        state_d   = ST_RD_REQ;
                    end else begin
                        upd_more_d = sent_q && more_q && (burst_idx_q == MAX_B);
                        state_d    = ST_SCHED_UPDATE;
                    end
                end
            end
            ST_SCHED_UPDATE: begin
                bus.sched_tx_update_val = 1'b1;
                if (bus.sched_tx_update_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flowid_q    <= '0;
            burst_idx_q <= '0;
            sent_q      <= 1'b0;
            more_q      <= 1'b0;
            upd_more_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flowid_q    <= flowid_d;
            burst_idx_q <= burst_idx_d;
            sent_q      <= sent_d;
            more_q      <= more_d;
            upd_more_q  <= upd_more_d;
        end
    end

    assign bus.sched_tx_update_flowid = flowid_q;
    assign bus.sched_tx_update_more   = upd_more_q;
    assign bus.burst_idx              = burst_idx_q;
    assign state_dbg_o                = state_q;

`ifdef TCP_TX_CTRL_STATS_EN
    logic [31:0] stat_pkts_q;
    logic [31:0] stat_events_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts_q   <= '0;
            stat_events_q <= '0;
        end else begin
            if (bus.tx_pkt_val && bus.tx_pkt_rdy) stat_pkts_q <= stat_pkts_q + 32'd1;
            if (bus.sched_tx_update_val && bus.sched_tx_update_rdy) stat_events_q <= stat_events_q + 32'd1;
        end
    end

    assign bus.stat_pkts_sent    = stat_pkts_q;
    assign bus.stat_sched_events = stat_events_q;
`else
    assign bus.stat_pkts_sent    = 32'd0;
    assign bus.stat_sched_events = 32'd0;
`endif

endmodule

// File: tb/tb_tcp_tx_ctrl_burst.sv
// Directed bench for tcp_tx_ctrl_burst: drives one scheduling event at a time and checks the
// observed handshake counts against hand-computed expectations.
module tb_tcp_tx_ctrl_burst;
  import tcp_pkg::*;

`ifdef TCP_TX_CTRL_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  tx_burst_state_e state_dbg;

  tcp_tx_ctrl_burst_if #(.FLOWID_W(8), .NUM_RD(4), .BURST_W(3)) bus ();

  tcp_tx_ctrl_burst #(
    .FLOWID_W(8), .NUM_RD(4), .RD_ONCE_MASK(4'b1000), .MAX_BURST(4), .BURST_W(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg_o(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // per-event observations
  int ev_req_cnt[4];
  int ev_store_cnt[4];
  int ev_resp_total, ev_calc_resp, ev_calc_cnt;
  int ev_pkts, ev_pkt_val_cycles, ev_wbs;
  int ev_reissue_err, ev_store_err;
  logic [7:0] ev_upd_flowid;
  logic ev_upd_more;
  logic [2:0] ev_upd_burst;

  int order[4] = '{2, 0, 3, 1};

  task automatic run_event(input logic [7:0] fid, input int order_mode, input bit early1,
                           input bit prod, input bit more, input int pkt_delay, input bit abort_in_pkt);
    int cyc = 0;
    bit done = 0;
    bit accepted = 0;
    int step = 0;
    int pkt_wait = 0;
    logic [3:0] pend = 4'b0;
    logic [3:0] issued_it = 4'b0;
    logic [3:0] req_hs, resp_hs;
    for (int c = 0; c < 4; c++) begin
      ev_req_cnt[c] = 0;
      ev_store_cnt[c] = 0;
    end
    ev_resp_total = 0; ev_calc_resp = -1; ev_calc_cnt = 0;
    ev_pkts = 0; ev_pkt_val_cycles = 0; ev_wbs = 0;
    ev_reissue_err = 0; ev_store_err = 0;
    ev_upd_flowid = 8'h00; ev_upd_more = 1'b0; ev_upd_burst = 3'd0;
    bus.sched_tx_req_val = 1'b1;
    bus.sched_tx_req_flowid = fid;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      if (accepted) begin
        bus.sched_tx_req_val = 1'b0;
        bus.sched_tx_req_flowid = ~fid;
      end
      bus.rd_req_rdy = (order_mode == 0) ? 4'hf : (4'b0001 << order[step % 4]);
      bus.rd_resp_val = pend | (early1 ? (bus.rd_req_val & 4'b0010) : 4'b0000);
      bus.datap_ctrl_produce_pkt = prod;
      bus.datap_ctrl_more_data = more;
      bus.tx_pkt_rdy = (pkt_wait >= pkt_delay);
      bus.next_tx_state_wr_req_rdy = 1'b1;
      bus.sched_tx_update_rdy = 1'b1;
      #1;
      if (bus.sched_tx_req_val && bus.tx_sched_req_rdy) accepted = 1;
      req_hs = bus.rd_req_val & bus.rd_req_rdy;
      resp_hs = bus.rd_resp_val & bus.rd_resp_rdy;
      if ((bus.rd_req_val & issued_it) != 4'b0) ev_reissue_err++;
      if (bus.ctrl_datap_store_rd !== resp_hs) ev_store_err++;
      issued_it = issued_it | req_hs;
      for (int c = 0; c < 4; c++) begin
        if (req_hs[c]) ev_req_cnt[c]++;
        if (bus.ctrl_datap_store_rd[c]) ev_store_cnt[c]++;
        if (resp_hs[c]) ev_resp_total++;
      end
      if (bus.rd_req_val != 4'b0) step++;
      pend = (pend & ~resp_hs) | req_hs;
      if (bus.ctrl_datap_store_calc) begin
        if (ev_calc_resp < 0) ev_calc_resp = ev_resp_total;
        ev_calc_cnt++;
        issued_it = 4'b0;
      end
      if (bus.tx_pkt_val) begin
        ev_pkt_val_cycles++;
        if (bus.tx_pkt_rdy) begin
          ev_pkts++;
          pkt_wait = 0;
        end else begin
          pkt_wait++;
          if (abort_in_pkt && pkt_wait >= 3) done = 1;
        end
      end
      if (bus.next_tx_state_wr_req_val && bus.next_tx_state_wr_req_rdy) ev_wbs++;
      if (bus.sched_tx_update_val && bus.sched_tx_update_rdy) begin
        ev_upd_flowid = bus.sched_tx_update_flowid;
        ev_upd_more = bus.sched_tx_update_more;
        ev_upd_burst = bus.burst_idx;
        done = 1;
      end
      cyc++;
    end
    bus.sched_tx_req_val = 1'b0;
    if (!done) check("event_timeout", 32'd1, 32'd0);
  endtask

  int idle_vals;

  initial begin
    bus.sched_tx_req_val = 1'b0;
    bus.sched_tx_req_flowid = 8'h00;
    bus.sched_tx_update_rdy = 1'b0;
    bus.rd_req_rdy = 4'b0;
    bus.rd_resp_val = 4'b0;
    bus.next_tx_state_wr_req_rdy = 1'b0;
    bus.tx_pkt_rdy = 1'b0;
    bus.datap_ctrl_produce_pkt = 1'b0;
    bus.datap_ctrl_more_data = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_req_rdy", 32'(bus.tx_sched_req_rdy), 32'd1);
    check("rst_rd_req_val", 32'(bus.rd_req_val), 32'd0);
    check("rst_rd_resp_rdy", 32'(bus.rd_resp_rdy), 32'd0);
    check("rst_outs", 32'({bus.tx_pkt_val, bus.next_tx_state_wr_req_val,
                           bus.sched_tx_update_val, bus.ctrl_datap_store_calc}), 32'd0);
    check("rst_burst_idx", 32'(bus.burst_idx), 32'd0);
    rst = 1'b0;

    // 1: single packet, no more data
    run_event(8'h12, 0, 0, 1, 0, 0, 0);
    check("t1_flowid", 32'(ev_upd_flowid), 32'h12);
    check("t1_more", 32'(ev_upd_more), 32'd0);
    check("t1_burst", 32'(ev_upd_burst), 32'd1);
    check("t1_pkts", ev_pkts, 1);
    check("t1_wbs", ev_wbs, 1);
    check("t1_reads", ev_req_cnt[0] + ev_req_cnt[1] + ev_req_cnt[2] + ev_req_cnt[3], 4);

    // 2: requests accepted one per cycle in order 2,0,3,1; packet held two cycles
    run_event(8'h34, 1, 0, 1, 0, 2, 0);
    check("t2_reissue", ev_reissue_err, 0);
    check("t2_req_each", 32'({ev_req_cnt[0] == 1, ev_req_cnt[1] == 1, ev_req_cnt[2] == 1, ev_req_cnt[3] == 1}), 32'hf);
    check("t2_calc_after_resp", ev_calc_resp, 4);
    check("t2_pkt_hold", ev_pkt_val_cycles, 3);
    check("t2_flowid", 32'(ev_upd_flowid), 32'h34);

    // 3: channel 1 response offered in the same cycle as its request handshake
    run_event(8'h56, 0, 1, 1, 0, 0, 0);
    check("t3_store1", ev_store_cnt[1], 1);
    check("t3_store_pulse", ev_store_err, 0);
    check("t3_calc_cnt", ev_calc_cnt, 1);

    // 4: full burst with data always remaining
    run_event(8'h78, 0, 0, 1, 1, 0, 0);
    check("t4_pkts", ev_pkts, 4);
    check("t4_wbs", ev_wbs, 4);
    check("t4_calc_cnt", ev_calc_cnt, 4);
    check("t4_rd_tx", ev_req_cnt[RD_TX_STATE], 4);
    check("t4_rd_rx", ev_req_cnt[RD_RX_STATE], 4);
    check("t4_rd_tail", ev_req_cnt[RD_TAIL_PTR], 4);
    check("t4_rd_tuple", ev_req_cnt[RD_TUPLE], 1);
    check("t4_more", 32'(ev_upd_more), 32'd1);
    check("t4_burst", 32'(ev_upd_burst), 32'd4);
    check("t4_reissue", ev_reissue_err, 0);

    // 5: calc declines to send despite more data
    run_event(8'h9a, 0, 0, 0, 1, 0, 0);
    check("t5_pkt_val", ev_pkt_val_cycles, 0);
    check("t5_wbs", ev_wbs, 1);
    check("t5_more", 32'(ev_upd_more), 32'd0);
    check("t5_burst", 32'(ev_upd_burst), 32'd0);

    check("stat_pkts", bus.stat_pkts_sent, STATS_EN ? 32'd7 : 32'd0);
    check("stat_events", bus.stat_sched_events, STATS_EN ? 32'd5 : 32'd0);

    // 6: reset while a packet is stalled
    run_event(8'hbc, 0, 0, 1, 1, 1000, 1);
    check("t6_in_pkt", 32'(state_dbg), 32'(ST_PKT_OUT));
    check("t6_pkt_val", 32'(bus.tx_pkt_val), 32'd1);
    bus.tx_pkt_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6_state", 32'(state_dbg), 32'(ST_IDLE));
    check("t6_req_rdy", 32'(bus.tx_sched_req_rdy), 32'd1);
    check("t6_pkt_val_off", 32'(bus.tx_pkt_val), 32'd0);
    check("t6_burst", 32'(bus.burst_idx), 32'd0);
    check("t6_stat_pkts", bus.stat_pkts_sent, 32'd0);
    check("t6_stat_events", bus.stat_sched_events, 32'd0);
    rst = 1'b0;
    idle_vals = 0;
    bus.next_tx_state_wr_req_rdy = 1'b1;
    bus.sched_tx_update_rdy = 1'b1;
    bus.tx_pkt_rdy = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.next_tx_state_wr_req_val || bus.sched_tx_update_val || bus.tx_pkt_val) idle_vals++;
    end
    check("t6_no_wb_report", idle_vals, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
